fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the write port of one 8-bit FIFO among 4 requesters.
- Round-robin selection with bounded bursts: a granted requester owns the FIFO write side for up to MAX_BURST words, then ownership rotates.
- Sits directly in front of the FIFO; drives its write/datain and observes its full flag.
- Requesters see a one-hot grant and a per-word ack.

Parameters:
- DATA_WIDTH, 8, word width; must match FIFO datain.
- MAX_BURST, 4, maximum words accepted per grant; legal range 1..15.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  req[i] high = requester i has a word on its data slice.
- req_data  input  4*DATA_WIDTH  requester i word on bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant  output  4  one-hot owner indication, registered; all-zero when idle.
- ack  output  4  one-hot, combinational; ack[i] high = requester i's word is written this cycle.
- fifo_write  output  1  combinational write strobe to FIFO.
- fifo_datain  output  DATA_WIDTH  word to FIFO, the owner's req_data slice.
- fifo_full  input  1  FIFO full flag.
- busy  output  1  registered; high while in GRANT state.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, grant=0, busy=0, burst count=0, priority pointer=0 (requester 0 highest).
- Combinational outputs: ack=0 and fifo_write=0 in the reset cycle and the cycle after.
- fifo_datain is don't-care when fifo_write=0; drive 0.
- Reset asserted mid-burst aborts immediately. No write occurs on the cycle following reset. The pointer returns to 0.

State IDLE:
- If req != 0, select the first requester with req set, scanning from the pointer upward modulo 4.
- Next cycle: state=GRANT, grant=onehot(sel), busy=1, count=0.
- No write is issued from IDLE. Minimum latency from req to first write is 1 cycle.

State GRANT (owner o):
- Write condition: wr = req[o] & ~fifo_full.
- When wr: fifo_write=1, fifo_datain=req_data slice o, ack[o]=1, count+1.
- Requester retires its word on ack and may present the next word in the same cycle.
- fifo_full high: hold grant, no write, count unchanged. No timeout.
- Release conditions:
  - req[o] low, or
  - wr and count+1 == MAX_BURST.
- On release: next state=IDLE, grant=0, busy=0, pointer=(o+1) mod 4.
- This gives exactly one idle bubble cycle between grants.
- Requesters other than the owner never see ack. Their req may change freely.
- fifo_write is never asserted while fifo_full=1.

Invariants:
- grant is zero or one-hot.
- ack is a subset of grant.
- fifo_write == |ack.
- count never exceeds MAX_BURST.

Test Plan:
- Reset: reset=1 with req=4'b1111 for 2 cycles → grant=0, busy=0, fifo_write=0 throughout. After release, first grant=4'b0001.
- Single requester: req=4'b0100 held, data 8'hA0..A7 incrementing per ack, MAX_BURST=4.
  - grant=4'b0100 from cycle 1.
  - Words A0..A3 written on cycles 1..4.
  - IDLE bubble on cycle 5; regrant on cycle 6; A4..A7 written on cycles 6..9.
- Round-robin: req=4'b1111 continuously → grant sequence 0001, 0010, 0100, 1000, 0001, each with 4 acks and a 1-cycle bubble between grants.
- Full stall: owner 1 granted, fifo_full=1 for cycles 2..4 →
  - fifo_write=0 and ack=0 on those cycles.
  - grant held, count frozen.
  - Burst completes after full drops, for 4 total words.
- Early drop: owner 3 drops req after 2 acks → release with count=2, pointer=0. Next req=4'b1001 grants requester 0.
- Mid-burst reset: reset on cycle 3 of a burst with owner 2 → next cycle grant=0, no write. With req=4'b0110 held, the following grant is 4'b0010 (pointer=0).

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Shares the write port of one FIFO among four requesters. Selection is
//   round-robin. A granted requester keeps the write side for up to MAX_BURST
//   words and then gives it up. There is always one idle cycle between grants.
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high
//   req[i]       requester i has a word on its req_data slice
//   req_data     requester i word on [i*DATA_WIDTH +: DATA_WIDTH]
//   grant        registered one-hot owner, zero when idle
//   ack          combinational one-hot, the owner's word is written this cycle
//   fifo_write   combinational FIFO write strobe
//   fifo_datain  owner's word while writing, otherwise zero
//   fifo_full    FIFO full flag, blocks writes while high
//   busy         registered, high while a grant is held
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                req,
  input  logic [4*DATA_WIDTH-1:0]   req_data,
  output logic [3:0]                grant,
  output logic [3:0]                ack,
  output logic                      fifo_write,
  output logic [DATA_WIDTH-1:0]     fifo_datain,
  input  logic                      fifo_full,
  output logic                      busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic        busy_q,  busy_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  ptr_q,   ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic        wr;
  logic        found;
  logic [1:0]  idx;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Output logic. The reset qualifier keeps a mid-burst reset from writing
  // in the cycle where reset is high but the registers still show GRANT.
  always_comb begin
    wr          = (state_q == GRANT) && req[owner_q] && !fifo_full && !reset;
    ack         = '0;
    fifo_write  = wr;
    fifo_datain = '0;
    if (wr) begin
      ack[owner_q] = 1'b1;
      fifo_datain  = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    found   = 1'b0;
    idx     = '0;
    case (state_q)
      IDLE: begin
        // Scan upward from the pointer. The 2-bit index wraps modulo 4.
        for (int unsigned i = 0; i < 4; i++) begin
          idx = ptr_q + 2'(i);
          if (!found && req[idx]) begin
            found   = 1'b1;
            owner_d = idx;
          end
        end
        if (found) begin
          state_d = GRANT;
          grant_d = 4'b0001 << owner_d;
          busy_d  = 1'b1;
          count_d = '0;
        end
      end
      GRANT: begin
        if (wr) count_d = count_q + 4'd1;
        if (!req[owner_q] || (wr && (count_q + 4'd1 == BURST_LAST))) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = owner_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: expected FIFO words are queued
// when a burst is set up and popped whenever the DUT writes.
module tb_fifo_write_arbiter;

  localparam int DW = 8;

  logic            clock;
  logic            reset;
  logic [3:0]      req;
  logic [4*DW-1:0] req_data;
  logic [3:0]      grant;
  logic [3:0]      ack;
  logic            fifo_write;
  logic [DW-1:0]   fifo_datain;
  logic            fifo_full;
  logic            busy;

  fifo_write_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .ack        (ack),
    .fifo_write (fifo_write),
    .fifo_datain(fifo_datain),
    .fifo_full  (fifo_full),
    .busy       (busy)
  );

  typedef struct packed {
    logic [1:0]    owner;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb_q[$];
  logic [DW-1:0] rd[4];
  logic [DW-1:0] exp_next[4];
  int            passed = 0;
  int            total  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply();
    req_data = {rd[3], rd[2], rd[1], rd[0]};
  endtask

  task automatic push_burst(input int owner, input int n);
    sb_t e;
    for (int k = 0; k < n; k++) begin
      e.owner = 2'(owner);
      e.data  = exp_next[owner];
      sb_q.push_back(e);
      exp_next[owner] = exp_next[owner] + 8'd1;
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    rd[i]       = v;
    exp_next[i] = v;
    apply();
  endtask

  // One clock cycle: check outputs mid-cycle, then advance requester data on ack.
  task automatic cyc(input logic [3:0] g_exp, input logic w_exp, input string tag);
    logic [3:0] ack_s;
    sb_t        e;
    @(negedge clock);
    chk({tag, "_grant"}, grant, g_exp);
    chk({tag, "_write"}, fifo_write, w_exp);
    chk({tag, "_busy"}, busy, (g_exp != 4'b0000));
    chk({tag, "_ack_in_grant"}, ack & ~grant, 0);
    chk({tag, "_write_eq_ack"}, fifo_write, |ack);
    if (fifo_write) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_underflow"}, 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk({tag, "_data"}, fifo_datain, e.data);
        chk({tag, "_ack"}, ack, 4'b0001 << e.owner);
      end
    end
    ack_s = ack;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++)
      if (ack_s[i]) rd[i] = rd[i] + 8'd1;
    apply();
  endtask

  initial begin
    reset     = 1'b1;
    req       = 4'b1111;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) set_word(i, 8'(16 * (i + 1)));
    @(posedge clock);
    #1;

    // Reset held with all requests high
    cyc(4'b0000, 1'b0, "rst");
    cyc(4'b0000, 1'b0, "rst");
    reset = 1'b0;

    // Round robin: 0,1,2,3,0 each for four words with one idle cycle between
    for (int r = 0; r < 5; r++) begin
      cyc(4'b0000, 1'b0, "rr_bubble");
      push_burst(r % 4, 4);
      for (int k = 0; k < 4; k++) cyc(4'b0001 << (r % 4), 1'b1, "rr");
    end
    req = 4'b0000;
    cyc(4'b0000, 1'b0, "idle");

    // Single requester 2, two back-to-back bursts A0..A7
    set_word(2, 8'hA0);
    req = 4'b0100;
    cyc(4'b0000, 1'b0, "single_c0");
    push_burst(2, 4);
    for (int k = 0; k < 4; k++) cyc(4'b0100, 1'b1, "single_b1");
    cyc(4'b0000, 1'b0, "single_bubble");
    push_burst(2, 4);
    for (int k = 0; k < 4; k++) cyc(4'b0100, 1'b1, "single_b2");
    req = 4'b0000;
    cyc(4'b0000, 1'b0, "single_idle");

    // Full stall: owner 1, full on cycles 2..4
    set_word(1, 8'h5C);
    req = 4'b0010;
    cyc(4'b0000, 1'b0, "stall_c0");
    push_burst(1, 4);
    cyc(4'b0010, 1'b1, "stall_c1");
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b0, "stall_full");
    fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b1, "stall_resume");
    req = 4'b0000;
    cyc(4'b0000, 1'b0, "stall_bubble");

    // Early drop: owner 3 leaves after two words, then requester 0 wins
    set_word(3, 8'hE0);
    req = 4'b1000;
    cyc(4'b0000, 1'b0, "drop_c0");
    push_burst(3, 2);
    for (int k = 0; k < 2; k++) cyc(4'b1000, 1'b1, "drop_wr");
    req = 4'b0000;
    cyc(4'b1000, 1'b0, "drop_release");
    set_word(0, 8'h07);
    req = 4'b1001;
    cyc(4'b0000, 1'b0, "drop_bubble");
    push_burst(0, 1);
    cyc(4'b0001, 1'b1, "drop_next");
    req = 4'b0000;
    cyc(4'b0001, 1'b0, "drop_next_release");
    cyc(4'b0000, 1'b0, "drop_idle");

    // Mid-burst reset: owner 2 interrupted in its third cycle
    set_word(2, 8'h30);
    req = 4'b0100;
    cyc(4'b0000, 1'b0, "mrst_c0");
    push_burst(2, 2);
    for (int k = 0; k < 2; k++) cyc(4'b0100, 1'b1, "mrst_wr");
    reset = 1'b1;
    cyc(4'b0100, 1'b0, "mrst_reset_cycle");
    reset = 1'b0;
    set_word(1, 8'h90);
    req = 4'b0110;
    cyc(4'b0000, 1'b0, "mrst_after");
    push_burst(1, 4);
    for (int k = 0; k < 4; k++) cyc(4'b0010, 1'b1, "mrst_regrant");
    req = 4'b0000;
    cyc(4'b0000, 1'b0, "mrst_bubble");

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
